// File: rtl/instr_mem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Imported by the loader interface, the top module and the bench.
package instr_mem_loader_pkg;

    localparam int DEF_DATA_WIDTH        = 8;
    localparam int DEF_ADDR_WIDTH        = 12;
    localparam int DEF_INSTRUCTION_WIDTH = 2 * DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        RUN
    } state_t;

    localparam logic [DEF_INSTRUCTION_WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Program-load port plus the core-facing PC/instruction bus of the loader.
// master = program source / core side, slave = loader.
interface instr_mem_loader_if
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int INSTRUCTION_WIDTH = 2 * DATA_WIDTH;

    logic                         LOAD_START;
    logic [DATA_WIDTH-1:0]        LOAD_DATA_IN;
    logic                         LOAD_VALID;
    logic                         LOAD_LAST;
    logic                         LOAD_READY;
    logic [ADDR_WIDTH-1:0]        PC_IN;
    logic [INSTRUCTION_WIDTH-1:0] INSTR_OUT;
    logic                         CPU_RESET_OUT;
    logic [ADDR_WIDTH-1:0]        LOAD_COUNT_OUT;
    logic                         LOAD_ERROR_OUT;

    modport master (
        output LOAD_START, LOAD_DATA_IN, LOAD_VALID, LOAD_LAST, PC_IN,
        input  LOAD_READY, INSTR_OUT, CPU_RESET_OUT, LOAD_COUNT_OUT, LOAD_ERROR_OUT
    );

    modport slave (
        input  LOAD_START, LOAD_DATA_IN, LOAD_VALID, LOAD_LAST, PC_IN,
        output LOAD_READY, INSTR_OUT, CPU_RESET_OUT, LOAD_COUNT_OUT, LOAD_ERROR_OUT
    );

endinterface

// File: rtl/instr_mem_loader_imem_sp_ram.sv
// Single-port synchronous RAM: write-enable port, registered read-before-write output.
module imem_sp_ram #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Packs a byte stream into instruction words, holds the core in reset while
// loading, then releases it and serves fetches bounded by the loaded size.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int INSTRUCTION_WIDTH = 2 * DATA_WIDTH,
    parameter int MEM_DEPTH         = 2 ** ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    instr_mem_loader_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                       state;
    logic                         load_ready;
    logic                         cpu_reset;
    logic                         instr_valid;
    logic                         load_error;
    logic                         full;
    logic [ADDR_WIDTH-1:0]        load_count;
    logic [DATA_WIDTH-1:0]        hi_byte;

    logic                         xfer;
    logic                         ram_we;
    logic [ADDR_WIDTH-1:0]        ram_addr;
    logic [INSTRUCTION_WIDTH-1:0] ram_rdata;

    assign xfer = bus.LOAD_VALID && load_ready;

    // A restart beats a concurrent low-byte transfer, so it also suppresses the write.
    assign ram_we   = (state == LOAD_LO) && xfer && !bus.LOAD_START;
    assign ram_addr = (state == LOAD_LO) ? load_count : bus.PC_IN;

    imem_sp_ram #(
        .WIDTH      (INSTRUCTION_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata ({hi_byte, bus.LOAD_DATA_IN}),
        .rdata (ram_rdata)
    );

    // NOTE: every register here is state, so it is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            load_ready  <= 1'b0;
            cpu_reset   <= 1'b1;
            instr_valid <= 1'b0;
            load_error  <= 1'b0;
            full        <= 1'b0;
            load_count  <= '0;
            hi_byte     <= '0;
        end else if (bus.LOAD_START) begin
            // Start, restart or abort-and-reload all begin a fresh load at word 0.
            state       <= LOAD_HI;
            load_ready  <= 1'b1;
            cpu_reset   <= 1'b1;
            instr_valid <= 1'b0;
            load_error  <= 1'b0;
            full        <= 1'b0;
            load_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cpu_reset   <= 1'b1;
                    instr_valid <= 1'b0;
                end
                LOAD_HI: begin
                    if (xfer) begin
                        if (bus.LOAD_LAST) begin
                            load_error <= 1'b1;
                            load_ready <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            hi_byte <= bus.LOAD_DATA_IN;
                            state   <= LOAD_LO;
                        end
                    end
                end
                LOAD_LO: begin
                    if (xfer) begin
                        load_count <= load_count + ADDR_ONE;
                        if (bus.LOAD_LAST) begin
                            // The count wraps to 0 on a completely full memory.
                            full       <= (load_count == LAST_ADDR);
                            load_ready <= 1'b0;
                            state      <= RUN;
                        end else if (load_count == LAST_ADDR) begin
                            load_error <= 1'b1;
                            load_ready <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= LOAD_HI;
                        end
                    end
                end
                RUN: begin
                    cpu_reset   <= 1'b0;
                    instr_valid <= full || (bus.PC_IN < load_count);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.LOAD_READY     = load_ready;
    assign bus.CPU_RESET_OUT  = cpu_reset;
    assign bus.LOAD_COUNT_OUT = load_count;
    assign bus.LOAD_ERROR_OUT = load_error;
    assign bus.INSTR_OUT      = instr_valid ? ram_rdata : NOP_INSTR;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: loads, fetch bounds, odd/overflow errors,
// reload from RUN, restart priority and reset mid-load.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    instr_mem_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) bus ();

    instr_mem_loader #(
        .DATA_WIDTH        (8),
        .ADDR_WIDTH        (12),
        .INSTRUCTION_WIDTH (16),
        .MEM_DEPTH         (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.LOAD_START = 1'b1;
        tick();
        bus.LOAD_START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic last);
        int waited = 0;
        bus.LOAD_DATA_IN = data;
        bus.LOAD_VALID   = 1'b1;
        bus.LOAD_LAST    = last;
        while (!bus.LOAD_READY && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.LOAD_READY) check("ready_timeout", 32'(bus.LOAD_READY), 32'd1);
        tick();
        bus.LOAD_VALID   = 1'b0;
        bus.LOAD_LAST    = 1'b0;
        bus.LOAD_DATA_IN = 8'hEE;
    endtask

    task automatic fetch(input string tag, input logic [11:0] pc, input logic [15:0] expected);
        bus.PC_IN = pc;
        tick();
        check(tag, 32'(bus.INSTR_OUT), 32'(expected));
    endtask

    initial begin
        logic [7:0] gap_bytes [6];
        gap_bytes[0] = 8'hA1; gap_bytes[1] = 8'hB2; gap_bytes[2] = 8'hC3;
        gap_bytes[3] = 8'hD4; gap_bytes[4] = 8'hE5; gap_bytes[5] = 8'hF6;

        reset            = 1'b1;
        bus.LOAD_START   = 1'b0;
        bus.LOAD_DATA_IN = 8'h00;
        bus.LOAD_VALID   = 1'b0;
        bus.LOAD_LAST    = 1'b0;
        bus.PC_IN        = '0;
        tick();
        tick();
        check("rst_ready", 32'(bus.LOAD_READY), 32'd0);
        check("rst_cpu_reset", 32'(bus.CPU_RESET_OUT), 32'd1);
        check("rst_instr", 32'(bus.INSTR_OUT), 32'd0);
        check("rst_count", 32'(bus.LOAD_COUNT_OUT), 32'd0);
        check("rst_error", 32'(bus.LOAD_ERROR_OUT), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_ready", 32'(bus.LOAD_READY), 32'd0);

        // Basic 2-word program
        start_load();
        check("load_ready_hi", 32'(bus.LOAD_READY), 32'd1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        check("basic_count", 32'(bus.LOAD_COUNT_OUT), 32'd2);
        check("basic_entry_cpu_reset", 32'(bus.CPU_RESET_OUT), 32'd1);
        check("basic_run_ready", 32'(bus.LOAD_READY), 32'd0);
        fetch("basic_pc0", 12'd0, 16'h1234);
        check("basic_cpu_released", 32'(bus.CPU_RESET_OUT), 32'd0);
        fetch("basic_pc1", 12'd1, 16'h5678);
        fetch("basic_pc2_oob", 12'd2, 16'h0000);

        // 3-word load with random gaps and junk data while invalid
        start_load();
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_byte(gap_bytes[i], i == 5);
        end
        check("gap_count", 32'(bus.LOAD_COUNT_OUT), 32'd3);
        check("gap_error", 32'(bus.LOAD_ERROR_OUT), 32'd0);
        fetch("gap_pc0", 12'd0, 16'hA1B2);
        fetch("gap_pc1", 12'd1, 16'hC3D4);
        fetch("gap_pc2", 12'd2, 16'hE5F6);
        fetch("gap_pc3_oob", 12'd3, 16'h0000);
        check("gap_run_ready", 32'(bus.LOAD_READY), 32'd0);

        // Odd-length program
        start_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check("odd_error", 32'(bus.LOAD_ERROR_OUT), 32'd1);
        check("odd_count", 32'(bus.LOAD_COUNT_OUT), 32'd1);
        check("odd_ready", 32'(bus.LOAD_READY), 32'd0);
        tick();
        tick();
        check("odd_cpu_reset", 32'(bus.CPU_RESET_OUT), 32'd1);
        check("odd_instr", 32'(bus.INSTR_OUT), 32'd0);

        // Overflow: 4096 words without LAST
        start_load();
        check("ovf_error_cleared", 32'(bus.LOAD_ERROR_OUT), 32'd0);
        for (int w = 0; w < 4096; w++) begin
            send_byte(8'hA0 | 8'(w >> 8), 1'b0);
            send_byte(8'(w), 1'b0);
        end
        check("ovf_error", 32'(bus.LOAD_ERROR_OUT), 32'd1);
        check("ovf_count_wrapped", 32'(bus.LOAD_COUNT_OUT), 32'd0);
        check("ovf_ready", 32'(bus.LOAD_READY), 32'd0);
        check("ovf_cpu_reset", 32'(bus.CPU_RESET_OUT), 32'd1);

        // Full 4096-word program with LAST on the final byte
        start_load();
        for (int w = 0; w < 4096; w++) begin
            send_byte(8'hA0 | 8'(w >> 8), 1'b0);
            send_byte(8'(w), w == 4095);
        end
        check("full_error", 32'(bus.LOAD_ERROR_OUT), 32'd0);
        check("full_count", 32'(bus.LOAD_COUNT_OUT), 32'd0);
        fetch("full_pc_fff", 12'hFFF, 16'hAFFF);
        check("full_cpu_released", 32'(bus.CPU_RESET_OUT), 32'd0);
        fetch("full_pc_000", 12'h000, 16'hA000);
        fetch("full_pc_800", 12'h800, 16'hA800);

        // Reload from RUN aborts execution
        start_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        fetch("reload_pre_pc1", 12'd1, 16'h0304);
        bus.PC_IN = 12'd0;
        start_load();
        check("reload_cpu_reset", 32'(bus.CPU_RESET_OUT), 32'd1);
        check("reload_instr", 32'(bus.INSTR_OUT), 32'd0);
        check("reload_ready", 32'(bus.LOAD_READY), 32'd1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hAA, 1'b1);
        check("reload_count", 32'(bus.LOAD_COUNT_OUT), 32'd1);
        fetch("reload_pc0", 12'd0, 16'hAAAA);
        fetch("reload_pc1_oob", 12'd1, 16'h0000);

        // Restart during LOAD_LO beats a concurrent transfer
        start_load();
        send_byte(8'h77, 1'b0);
        bus.LOAD_DATA_IN = 8'h88;
        bus.LOAD_VALID   = 1'b1;
        start_load();
        bus.LOAD_VALID   = 1'b0;
        check("restart_count", 32'(bus.LOAD_COUNT_OUT), 32'd0);
        check("restart_ready", 32'(bus.LOAD_READY), 32'd1);
        send_byte(8'h9A, 1'b0);
        send_byte(8'hBC, 1'b1);
        check("restart_final_count", 32'(bus.LOAD_COUNT_OUT), 32'd1);
        fetch("restart_pc0", 12'd0, 16'h9ABC);

        // Reset asserted while in LOAD_LO
        start_load();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        check("midrst_pre_count", 32'(bus.LOAD_COUNT_OUT), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", 32'(bus.LOAD_READY), 32'd0);
        check("midrst_count", 32'(bus.LOAD_COUNT_OUT), 32'd0);
        check("midrst_error", 32'(bus.LOAD_ERROR_OUT), 32'd0);
        check("midrst_cpu_reset", 32'(bus.CPU_RESET_OUT), 32'd1);
        check("midrst_instr", 32'(bus.INSTR_OUT), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction-side responder for the processor core. It accepts a program as a byte stream over a valid/ready load port and packs bytes into INSTRUCTION_WIDTH words in an internal instruction memory.
- After loading, it holds the core in reset, then releases it and serves instruction fetches addressed by the core's PC output.
- Sits between the external program source and the core's PC/instruction interface.

Parameters:
DATA_WIDTH, 8, width of one load byte (matches core data width)
ADDR_WIDTH, 12, PC / instruction-memory address width
INSTRUCTION_WIDTH, 16, fetched word width; fixed at 2*DATA_WIDTH
MEM_DEPTH, 4096, number of instruction words; must equal 2**ADDR_WIDTH

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
LOAD_START  in  1  pulse: begin a new program load
LOAD_DATA_IN  in  DATA_WIDTH  program byte, high byte of each word first
LOAD_VALID  in  1  LOAD_DATA_IN valid
LOAD_LAST  in  1  qualifies the final byte of the program
LOAD_READY  out  1  loader accepts a byte this cycle
PC_IN  in  ADDR_WIDTH  fetch address from the core's PC output
INSTR_OUT  out  INSTRUCTION_WIDTH  fetched instruction word
CPU_RESET_OUT  out  1  reset for the core; high except in RUN
LOAD_COUNT_OUT  out  ADDR_WIDTH  number of words written in the current/last load
LOAD_ERROR_OUT  out  1  sticky error from the last load attempt

Behaviour:
- Reset values:
  - State IDLE.
  - LOAD_READY=0, CPU_RESET_OUT=1, INSTR_OUT=0, LOAD_COUNT_OUT=0, LOAD_ERROR_OUT=0.
  - Memory contents are not cleared.
- A byte is transferred only when LOAD_VALID=1 and LOAD_READY=1 in the same cycle. LOAD_READY is registered and equals 1 exactly in LOAD_HI and LOAD_LO.
- FSM states are IDLE, LOAD_HI, LOAD_LO, RUN.
- IDLE:
  - CPU_RESET_OUT=1.
  - LOAD_START -> LOAD_HI; clears LOAD_COUNT_OUT and LOAD_ERROR_OUT.
- LOAD_HI:
  - On transfer, capture the high byte and go to LOAD_LO.
  - Transfer with LOAD_LAST=1 is an odd-length program: set LOAD_ERROR_OUT, go to IDLE, write nothing.
- LOAD_LO:
  - On transfer, write {hi,lo} to mem[LOAD_COUNT_OUT] and increment LOAD_COUNT_OUT.
  - If LOAD_LAST=1, go to RUN.
  - Else if the word just written was at address MEM_DEPTH-1 (overflow), set LOAD_ERROR_OUT and go to IDLE.
  - Otherwise go to LOAD_HI.
- Loads of exactly MEM_DEPTH words leave LOAD_COUNT_OUT wrapped to 0. In RUN, a count of 0 therefore means "full" in that case only; implement with a separate full flag.
- RUN:
  - CPU_RESET_OUT=0 starting the cycle after entry, so the core sees at least one reset cycle after the last write.
  - Each cycle: INSTR_OUT <= mem[PC_IN] if PC_IN < loaded count (or the full flag is set); otherwise INSTR_OUT <= 0. Read latency is 1 cycle.
  - LOAD_START in RUN -> LOAD_HI and CPU_RESET_OUT=1 from the next cycle (reload aborts execution).
- Outside RUN, INSTR_OUT=0.
- Simultaneous events:
  - LOAD_START during LOAD_HI or LOAD_LO restarts the load at word 0 and discards any captured high byte; the restart has priority over a concurrent transfer.
  - reset has priority over everything.
- Reset mid-load returns to IDLE. Words already written stay in memory but are unreachable, because the count is 0.
- Memory never written in a cycle in which it is read; a single-port array is sufficient.

Decomposition:
- Shared package holds:
  - State enum {IDLE, LOAD_HI, LOAD_LO, RUN}.
  - Constants for DATA_WIDTH, ADDR_WIDTH and INSTRUCTION_WIDTH defaults.
  - NOP/blank instruction constant 0.
- Sub-module imem_sp_ram: single-port synchronous RAM with registered read and write enable, parameterised by width and depth.
- FSM, byte packer, count/full logic and bound check stay in instr_mem_loader.

Test Plan:
- Reset then stream bytes 12 34 56 78 (LAST on 78) -> mem[0]=1234, mem[1]=5678, LOAD_COUNT_OUT=2, RUN, CPU_RESET_OUT falls 1 cycle after entry; PC_IN=1 -> INSTR_OUT=5678 next cycle; PC_IN=2 -> 0000.
- LOAD_VALID toggled randomly with gaps during a 3-word load -> only handshaken bytes stored, words exact, LOAD_READY=0 in IDLE/RUN.
- 3-byte program (LAST on 3rd byte) -> LOAD_ERROR_OUT=1, state IDLE, LOAD_COUNT_OUT=1, CPU_RESET_OUT stays 1.
- 4096 words without LAST -> error after write to 0xFFF, IDLE. Repeat with LAST on the final byte -> RUN, PC_IN=0xFFF returns the last word.
- LOAD_START in RUN after a 2-word program -> CPU_RESET_OUT=1 next cycle, INSTR_OUT=0. Reload 1 word AAAA -> PC_IN=1 returns 0000.
- reset asserted during LOAD_LO -> IDLE, count 0, error 0, CPU_RESET_OUT=1, INSTR_OUT=0 on the next cycle.
